host_mem_responder: RTL

- Memory-side responder for the single-word host request protocol that our HLS kernel wrappers use as initiators.
- Accepts one read or write request at a time on read_enable/write_enable with a 64-bit byte address.
- Services the request against an internal word array after a fixed latency, then pulses read_ready/write_ready for one cycle.
- Used as the behavioural host memory in wrapper benches and as an on-chip backing store in standalone FPGA builds.

---
 rtl/host_mem_pkg.sv | 17 +
 rtl/host_mem_responder_if.sv | 29 ++
 rtl/host_mem_array.sv | 33 +++
 rtl/host_mem_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/host_mem_pkg.sv
// rtl/host_mem_pkg.sv - shared state encoding and constants for host_mem_responder
package host_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    localparam int ERR_RANGE = 0;
    localparam int ERR_ALIGN = 1;
    localparam int ERR_PROTO = 2;

    localparam logic [63:0] WORD_BYTES = 64'd4;
    localparam int          CNT_W      = 16;

endpackage

// File: rtl/host_mem_responder_if.sv
// rtl/host_mem_responder_if.sv - single-word host request bus between initiator and memory responder
interface host_mem_responder_if #(
    parameter int DATA_WID = 32
);
    logic [63:0]         read_base;
    logic [63:0]         write_base;
    logic                read_enable;
    logic [63:0]         read_addr;
    logic [63:0]         read_size;
    logic                write_enable;
    logic [63:0]         write_addr;
    logic [63:0]         write_size;
    logic [DATA_WID-1:0] write_data;
    logic [63:0]         read_ready;
    logic [DATA_WID-1:0] read_data;
    logic [63:0]         write_ready;

    modport master (
        output read_base, write_base, read_enable, read_addr, read_size,
        output write_enable, write_addr, write_size, write_data,
        input  read_ready, read_data, write_ready
    );

    modport slave (
        input  read_base, write_base, read_enable, read_addr, read_size,
        input  write_enable, write_addr, write_size, write_data,
        output read_ready, read_data, write_ready
    );
endinterface

// File: rtl/host_mem_array.sv
// rtl/host_mem_array.sv - word RAM with synchronous write and registered, enabled read
module host_mem_array #(
    parameter int ADDR_WID = 16,
    parameter int DATA_WID = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                we,
    input  logic [ADDR_WID-1:0] waddr,
    input  logic [DATA_WID-1:0] wdata,
    input  logic                re,
    input  logic [ADDR_WID-1:0] raddr,
    output logic [DATA_WID-1:0] rdata
);

    logic [DATA_WID-1:0] mem [2**ADDR_WID];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register only loads on a read completion, so it holds the last result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/host_mem_responder.sv
// rtl/host_mem_responder.sv - fixed-latency single-word memory responder for HLS wrapper host requests
module host_mem_responder
    import host_mem_pkg::*;
#(
    parameter int ADDR_WID      = 16,
    parameter int DATA_WID      = 32,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    host_mem_responder_if.slave bus,
    input  logic                init_we,
    input  logic [ADDR_WID-1:0] init_addr,
    input  logic [DATA_WID-1:0] init_data,
    output logic [2:0]          err,
    output logic [31:0]         rd_count,
    output logic [31:0]         wr_count
);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                pend_rd, pend_rd_n;
    logic [ADDR_WID-1:0] rd_idx, rd_idx_n, wr_idx, wr_idx_n;
    logic                rd_bad, rd_bad_n, wr_drop, wr_drop_n;
    logic [DATA_WID-1:0] wr_data, wr_data_n;
    logic                rd_rdy, rd_rdy_n, wr_rdy, wr_rdy_n;
    logic                rd_zero, rd_zero_n;
    logic [2:0]          err_n;
    logic [31:0]         rd_count_n, wr_count_n;

    logic [63:0]         rd_diff, wr_diff;
    logic                rd_oob, rd_mis, rd_szbad, wr_oob, wr_mis, wr_szbad;
    logic                take_rd, take_wr, commit, mem_re;
    logic                mem_we;
    logic [ADDR_WID-1:0] mem_waddr;
    logic [DATA_WID-1:0] mem_wdata, mem_rdata;

    // Range check runs on the full 64-bit difference; truncation to the index comes after.
    assign rd_diff  = bus.read_addr - bus.read_base;
    assign rd_oob   = (bus.read_addr < bus.read_base) || ((rd_diff >> (ADDR_WID + 2)) != 64'd0);
    assign rd_mis   = bus.read_addr[1:0] != 2'b00;
    assign rd_szbad = bus.read_size != WORD_BYTES;
    assign wr_diff  = bus.write_addr - bus.write_base;
    assign wr_oob   = (bus.write_addr < bus.write_base) || ((wr_diff >> (ADDR_WID + 2)) != 64'd0);
    assign wr_mis   = bus.write_addr[1:0] != 2'b00;
    assign wr_szbad = bus.write_size != WORD_BYTES;

    assign take_wr = (state == IDLE) && bus.write_enable;
    assign take_rd = (state == IDLE) && bus.read_enable;
    assign commit  = (state == WR_WAIT) && (cnt == CNT_W'(1)) && !wr_drop;
    assign mem_re  = (state == RD_WAIT) && (cnt == CNT_W'(1));

    // Protocol commit owns the write port in its cycle; a coincident preload is dropped.
    assign mem_we    = commit || init_we;
    assign mem_waddr = commit ? wr_idx  : init_addr;
    assign mem_wdata = commit ? wr_data : init_data;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        pend_rd_n  = pend_rd;
        rd_idx_n   = rd_idx;
        rd_bad_n   = rd_bad;
        wr_idx_n   = wr_idx;
        wr_drop_n  = wr_drop;
        wr_data_n  = wr_data;
        rd_rdy_n   = 1'b0;
        wr_rdy_n   = 1'b0;
        rd_zero_n  = rd_zero;
        err_n      = err;
        rd_count_n = rd_count;
        wr_count_n = wr_count;

        case (state)
            IDLE: begin
                if (bus.write_enable) begin
                    cnt_n   = CNT_W'(WRITE_LATENCY);
                    state_n = WR_WAIT;
                    if (bus.read_enable) begin
                        err_n[ERR_PROTO] = 1'b1;
                        pend_rd_n        = 1'b1;
                    end
                end else if (bus.read_enable) begin
                    cnt_n   = CNT_W'(READ_LATENCY);
                    state_n = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.read_enable || bus.write_enable) begin
                    err_n[ERR_PROTO] = 1'b1;
                end
                if (cnt == CNT_W'(1)) begin
                    rd_zero_n  = rd_bad;
                    rd_rdy_n   = 1'b1;
                    rd_count_n = rd_count + 32'd1;
                    cnt_n      = '0;
                    state_n    = IDLE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            WR_WAIT: begin
                if (bus.read_enable || bus.write_enable) begin
                    err_n[ERR_PROTO] = 1'b1;
                end
                if (cnt == CNT_W'(1)) begin
                    wr_rdy_n   = 1'b1;
                    wr_count_n = wr_count + 32'd1;
                    if (pend_rd) begin
                        pend_rd_n = 1'b0;
                        cnt_n     = CNT_W'(READ_LATENCY);
                        state_n   = RD_WAIT;
                    end else begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        if (take_wr) begin
            wr_idx_n         = wr_diff[ADDR_WID+1:2];
            wr_data_n        = bus.write_data;
            wr_drop_n        = wr_oob || wr_mis;
            err_n[ERR_RANGE] = err_n[ERR_RANGE] | wr_oob;
            err_n[ERR_ALIGN] = err_n[ERR_ALIGN] | wr_mis | wr_szbad;
        end
        if (take_rd) begin
            rd_idx_n         = rd_diff[ADDR_WID+1:2];
            rd_bad_n         = rd_oob || rd_mis;
            err_n[ERR_RANGE] = err_n[ERR_RANGE] | rd_oob;
            err_n[ERR_ALIGN] = err_n[ERR_ALIGN] | rd_mis | rd_szbad;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            pend_rd  <= 1'b0;
            rd_idx   <= '0;
            rd_bad   <= 1'b0;
            wr_idx   <= '0;
            wr_drop  <= 1'b0;
            wr_data  <= '0;
            rd_rdy   <= 1'b0;
            wr_rdy   <= 1'b0;
            rd_zero  <= 1'b0;
            err      <= '0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pend_rd  <= pend_rd_n;
            rd_idx   <= rd_idx_n;
            rd_bad   <= rd_bad_n;
            wr_idx   <= wr_idx_n;
            wr_drop  <= wr_drop_n;
            wr_data  <= wr_data_n;
            rd_rdy   <= rd_rdy_n;
            wr_rdy   <= wr_rdy_n;
            rd_zero  <= rd_zero_n;
            err      <= err_n;
            rd_count <= rd_count_n;
            wr_count <= wr_count_n;
        end
    end

    host_mem_array #(
        .ADDR_WID (ADDR_WID),
        .DATA_WID (DATA_WID)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .re      (mem_re),
        .raddr   (rd_idx),
        .rdata   (mem_rdata)
    );

    assign bus.read_data   = rd_zero ? '0 : mem_rdata;
    assign bus.read_ready  = {63'd0, rd_rdy};
    assign bus.write_ready = {63'd0, wr_rdy};

endmodule
